// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity checker.
package serial_parity_pkg;

  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/parity_xor_cell.sv
// One-bit parity accumulator update: acc XOR bit, built as a 2:1 mux.
module parity_xor_cell (
  input  logic acc,
  input  logic bit_in,
  output logic acc_next
);

  // bit_in selects between passing acc through and inverting it
  assign acc_next = bit_in ? ~acc : acc;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity checker: accumulates a bit-serial frame, then holds the result until it is taken.
// Optional macro SERIAL_PARITY_ODD_EN selects odd parity (default is even parity).
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int MAX_LEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic             up_data,
  input  logic             up_last,
  output logic             up_ready,
  output logic             down_valid,
  input  logic             down_ready,
  output logic             down_err,
  output logic             down_ovf,
  output logic [LEN_W-1:0] down_len
);

`ifdef SERIAL_PARITY_ODD_EN
  localparam logic EXPECTED = 1'b1;
`else
  localparam logic EXPECTED = 1'b0;
`endif

  state_t           state, state_nxt;
  logic             acc, ovf;
  logic [LEN_W-1:0] cnt;

  logic             xfer;
  logic             acc_base, acc_upd;
  logic [LEN_W-1:0] cnt_inc;
  logic             hit_max;

  assign xfer = up_valid && up_ready;

  // The first beat of a frame loads the accumulator instead of folding into stale state.
  assign acc_base = (state == IDLE) ? 1'b0 : acc;
  assign cnt_inc  = (state == IDLE) ? LEN_W'(1) : cnt + LEN_W'(1);
  assign hit_max  = (cnt_inc == LEN_W'(MAX_LEN));

  parity_xor_cell u_xor (
    .acc      (acc_base),
    .bit_in   (up_data),
    .acc_next (acc_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = up_last ? HOLD : ACCUM;
      ACCUM:   if (xfer && (up_last || hit_max)) state_nxt = HOLD;
      HOLD:    if (down_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    up_ready   = (state != HOLD);
    down_valid = (state == HOLD);
    down_len   = '0;
    down_ovf   = 1'b0;
    down_err   = 1'b0;
    if (state == HOLD) begin
      down_len = cnt;
      down_ovf = ovf;
      down_err = (acc ^ EXPECTED) | ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 1'b0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == HOLD) begin
      if (down_ready) begin
        acc <= 1'b0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end else if (xfer) begin
      acc <= acc_upd;
      cnt <= cnt_inc;
      // A frame that fills up without its last marker is closed as an overflow.
      if (!up_last && hit_max) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench for serial_parity_checker, with a frame-level parity reference model.
module tb_serial_parity_checker;

  localparam int ML = 4;
`ifdef SERIAL_PARITY_ODD_EN
  localparam bit EXP = 1'b1;
`else
  localparam bit EXP = 1'b0;
`endif

  typedef bit bq_t[$];

  logic       clk = 1'b0;
  logic       rst, up_valid, up_data, up_last, down_ready;
  logic       up_ready, down_valid, down_err, down_ovf;
  logic [7:0] down_len;

  int errors = 0;
  int checks = 0;

  serial_parity_checker #(.MAX_LEN(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_last    (up_last),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_err   (down_err),
    .down_ovf   (down_ovf),
    .down_len   (down_len)
  );

  always #5 clk = ~clk;

  // Frame-level model: {valid, len, err, ovf} from the list of beats and whether it was terminated.
  function automatic logic [10:0] ref_result(input bq_t bits, input bit has_last);
    int ones = 0;
    bit ovf, err;
    foreach (bits[i]) ones += int'(bits[i]);
    ovf = !has_last;
    err = ((ones % 2) != int'(EXP)) || ovf;
    return {1'b1, 8'(bits.size()), err, ovf};
  endfunction

  function automatic logic [10:0] obs();
    return {down_valid, down_len, down_err, down_ovf};
  endfunction

  // First beat on the air comes from the MSB of v[n-1:0].
  function automatic bq_t mkq(input logic [7:0] v, input int n);
    bq_t q;
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
    return q;
  endfunction

  // Called at a negedge; returns at the negedge right after the beat transferred.
  task automatic push(input bit d, input bit l);
    int n = 0;
    up_valid = 1'b1; up_data = d; up_last = l;
    while (!up_ready && n < 20) begin @(negedge clk); n++; end
    if (!up_ready) begin
      errors++; checks++;
      $display("FAIL push_timeout: up_ready=%0b want 1", up_ready);
    end
    @(negedge clk);
    up_valid = 1'b0; up_last = 1'b0;
  endtask

  task automatic send_frame(input bq_t q, input bit has_last, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      push(q[i], has_last && (i == q.size() - 1));
    end
  endtask

  task automatic handshake();
    down_ready = 1'b1;
    @(negedge clk);
    down_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] o;
    rst = 1'b1; up_valid = 1'b1; up_data = 1'b1; up_last = 1'b1; down_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    o = obs();
    checks++; if (o !== 11'd0) begin errors++; $display("FAIL reset_outputs: got %h want 000", o); end
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", up_ready); end
    rst = 1'b0; up_valid = 1'b0; up_last = 1'b0;
    @(negedge clk);
    o = obs();
    checks++; if (o !== 11'd0) begin errors++; $display("FAIL reset_idle: got %h want 000", o); end
  endtask

  task automatic test_basic();
    bq_t q;
    logic [10:0] e, o;
    q = mkq(8'b1010, 4);
    send_frame(q, 1'b1, 1'b0);
    e = ref_result(q, 1'b1); o = obs();
    checks++; if (o !== e) begin errors++; $display("FAIL basic_result: got %h want %h", o, e); end
    handshake();
    o = obs();
    checks++; if (o !== 11'd0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release: got %h ready=%b want 000 ready=1", o, up_ready);
    end
    q = mkq(8'b1110, 4);
    send_frame(q, 1'b1, 1'b0);
    e = ref_result(q, 1'b1); o = obs();
    checks++; if (o !== e) begin errors++; $display("FAIL parity_err: got %h want %h", o, e); end
    handshake();
  endtask

  task automatic test_one_beat();
    bq_t q;
    logic [10:0] e, o;
    for (int b = 0; b < 2; b++) begin
      q = mkq(8'(b), 1);
      send_frame(q, 1'b1, 1'b0);
      e = ref_result(q, 1'b1); o = obs();
      checks++; if (o !== e) begin errors++; $display("FAIL one_beat_%0d: got %h want %h", b, o, e); end
      handshake();
    end
  endtask

  task automatic test_overflow();
    bq_t q;
    logic [10:0] e, o;
    q = mkq(8'b1011, 4);
    send_frame(q, 1'b0, 1'b0);
    e = ref_result(q, 1'b0); o = obs();
    checks++; if (o !== e) begin errors++; $display("FAIL ovf_result: got %h want %h", o, e); end
    up_valid = 1'b1; up_data = 1'b1;
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL ovf_hold_ready: got %b want 0", up_ready); end
    @(negedge clk);
    o = obs();
    checks++; if (o !== e) begin errors++; $display("FAIL ovf_stable: got %h want %h", o, e); end
    up_valid = 1'b0;
    handshake();
    q = mkq(8'b10, 2);
    send_frame(q, 1'b1, 1'b0);
    e = ref_result(q, 1'b1); o = obs();
    checks++; if (o !== e) begin errors++; $display("FAIL ovf_next_frame: got %h want %h", o, e); end
    handshake();
  endtask

  task automatic test_hold_stall();
    bq_t q;
    logic [10:0] e, o;
    q = mkq(8'b011, 3);
    send_frame(q, 1'b1, 1'b0);
    e = ref_result(q, 1'b1);
    up_valid = 1'b1; up_data = 1'b0; up_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      o = obs();
      checks++; if (o !== e || up_ready !== 1'b0) begin
        errors++; $display("FAIL stall_cycle%0d: got %h ready=%b want %h ready=0", c, o, up_ready, e);
      end
      @(negedge clk);
    end
    up_valid = 1'b0; up_last = 1'b0;
    handshake();
    o = obs();
    checks++; if (o !== 11'd0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: got %h ready=%b want 000 ready=1", o, up_ready);
    end
  endtask

  task automatic test_reset_mid();
    bq_t q;
    logic [10:0] e, o;
    push(1'b1, 1'b0);
    push(1'b1, 1'b0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    q = mkq(8'b01, 2);
    send_frame(q, 1'b1, 1'b0);
    e = ref_result(q, 1'b1); o = obs();
    checks++; if (o !== e) begin errors++; $display("FAIL reset_partial: got %h want %h", o, e); end
    rst = 1'b1; down_ready = 1'b0; @(negedge clk); rst = 1'b0;
    o = obs();
    checks++; if (o !== 11'd0 || up_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hold: got %h ready=%b want 000 ready=1", o, up_ready);
    end
  endtask

  task automatic test_back_to_back();
    bq_t q;
    logic [10:0] e, o;
    down_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      q = mkq(8'($urandom), $urandom_range(1, ML));
      send_frame(q, 1'b1, 1'b0);
      e = ref_result(q, 1'b1); o = obs();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_frame%0d: got %h want %h", f, o, e); end
    end
    @(negedge clk);
    down_ready = 1'b0;
  endtask

  task automatic test_random();
    bq_t q;
    bit term;
    logic [10:0] e, o;
    for (int f = 0; f < 40; f++) begin
      term = ($urandom_range(0, 4) != 0);
      q = mkq(8'($urandom), term ? $urandom_range(1, ML) : ML);
      send_frame(q, term, 1'b1);
      e = ref_result(q, term); o = obs();
      checks++; if (o !== e) begin errors++; $display("FAIL rand_frame%0d: got %h want %h", f, o, e); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      o = obs();
      checks++; if (o !== e) begin errors++; $display("FAIL rand_hold%0d: got %h want %h", f, o, e); end
      handshake();
    end
  endtask

  initial begin
    rst = 1'b1; up_valid = 1'b0; up_data = 1'b0; up_last = 1'b0; down_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_one_beat();
    test_overflow();
    test_hold_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
